// File: rtl/tmds_encoder_mc.sv
// Multi-lane two-stage TMDS/HDMI encoder: control, video, guard-band and TERC4 modes
// with a per-lane running-disparity counter.
module tmds_encoder_mc #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DISP_W = 5
) (
    input  logic                       pi_clk,
    input  logic                       pi_rst,
    input  logic                       pi_ce,
    input  logic [2:0]                 pi_mode,
    input  logic [NUM_CH*8-1:0]        pi_data,
    input  logic [NUM_CH*2-1:0]        pi_control,
    input  logic [NUM_CH*4-1:0]        pi_terc4,
    output logic [NUM_CH*10-1:0]       po_data,
    output logic                       po_valid,
    output logic [NUM_CH*DISP_W-1:0]   po_disparity
);

    if (DISP_W < 5) begin : g_disp_w_chk
        $error("tmds_encoder_mc: DISP_W must be at least 5");
    end

    typedef enum logic [2:0] {
        ModeCtrl  = 3'd0,
        ModeVideo = 3'd1,
        ModeVgb   = 3'd2,
        ModeTerc4 = 3'd3,
        ModeDigb  = 3'd4
    } mode_e;

    typedef logic signed [DISP_W+1:0] acc_t;
    localparam acc_t Zero  = acc_t'(0);
    localparam acc_t Two   = acc_t'(2);
    localparam acc_t Eight = acc_t'(8);

    localparam logic [9:0] GuardA = 10'b1011001100;
    localparam logic [9:0] GuardB = 10'b0100110011;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] n);
        logic [9:0] c;
        case (n)
            4'h0: c = 10'b1010011100;  4'h1: c = 10'b1001100011;
            4'h2: c = 10'b1011100100;  4'h3: c = 10'b1011100010;
            4'h4: c = 10'b0101110001;  4'h5: c = 10'b0100011110;
            4'h6: c = 10'b0110001110;  4'h7: c = 10'b0100111100;
            4'h8: c = 10'b1011001100;  4'h9: c = 10'b0100111001;
            4'hA: c = 10'b0110011100;  4'hB: c = 10'b1011000110;
            4'hC: c = 10'b1010001110;  4'hD: c = 10'b1001110001;
            4'hE: c = 10'b0101100011;  default: c = 10'b1011000011;
        endcase
        return c;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] r;
        case (c)
            2'b00:   r = 10'b1101010100;
            2'b01:   r = 10'b0010101011;
            2'b10:   r = 10'b0101010100;
            default: r = 10'b1010101011;
        endcase
        return r;
    endfunction

    // Stage 1 state
    mode_e                          mode_q, mode_d;
    logic [NUM_CH-1:0][8:0]         qm_q, qm_d;
    logic [NUM_CH-1:0][3:0]         n1_q, n1_d;
    logic [NUM_CH-1:0][9:0]         code_q, code_d;
    logic                           valid1_q, valid1_d;
    // Stage 2 state
    logic [NUM_CH-1:0][9:0]         data_q, data_d;
    logic [NUM_CH-1:0][DISP_W-1:0]  disp_q, disp_d;
    logic                           valid2_q, valid2_d;

    always_comb begin
        logic [7:0] d;
        logic [7:0] qm;
        logic       use_xnor;
        mode_d   = (pi_mode > 3'd4) ? ModeCtrl : mode_e'(pi_mode);
        valid1_d = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            d        = pi_data[k*8 +: 8];
            use_xnor = (popcnt8(d) > 4'd4) || ((popcnt8(d) == 4'd4) && !d[0]);
            qm[0]    = d[0];
            for (int i = 1; i < 8; i++) begin
                qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
            end
            qm_d[k] = {~use_xnor, qm};
            n1_d[k] = popcnt8(qm);
            case (mode_d)
                ModeCtrl:  code_d[k] = ctrl_code(pi_control[k*2 +: 2]);
                ModeVgb:   code_d[k] = (k % 3 == 1) ? GuardB : GuardA;
                ModeTerc4: code_d[k] = terc4_code(pi_terc4[k*4 +: 4]);
                ModeDigb:  code_d[k] = (k % 3 == 0) ? terc4_code(pi_terc4[k*4 +: 4]) : GuardB;
                default:   code_d[k] = 10'd0;
            endcase
        end
    end

    always_comb begin
        acc_t       cnt;
        acc_t       bal;
        acc_t       nxt;
        logic       q8;
        logic [7:0] qm;
        valid2_d = valid1_q;
        for (int k = 0; k < NUM_CH; k++) begin
            q8  = qm_q[k][8];
            qm  = qm_q[k][7:0];
            cnt = acc_t'(signed'(disp_q[k]));
            bal = (acc_t'(n1_q[k]) <<< 1) - Eight;  // N1 - N0
            nxt = Zero;
            data_d[k] = code_q[k];
            if (mode_q == ModeVideo) begin
                if ((cnt == Zero) || (n1_q[k] == 4'd4)) begin
                    data_d[k] = {~q8, q8, (q8 ? qm : ~qm)};
                    nxt       = q8 ? (cnt + bal) : (cnt - bal);
                end else if (((cnt > Zero) && (n1_q[k] > 4'd4)) ||
                             ((cnt < Zero) && (n1_q[k] < 4'd4))) begin
                    data_d[k] = {1'b1, q8, ~qm};
                    nxt       = cnt + (q8 ? Two : Zero) - bal;
                end else begin
                    data_d[k] = {1'b0, q8, qm};
                    nxt       = cnt - (q8 ? Zero : Two) + bal;
                end
            end
            disp_d[k] = nxt[DISP_W-1:0];
        end
    end

    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            mode_q   <= ModeCtrl;
            qm_q     <= '0;
            n1_q     <= '0;
            code_q   <= '0;
            valid1_q <= 1'b0;
            data_q   <= '0;
            disp_q   <= '0;
            valid2_q <= 1'b0;
        end else if (pi_ce) begin
            mode_q   <= mode_d;
            qm_q     <= qm_d;
            n1_q     <= n1_d;
            code_q   <= code_d;
            valid1_q <= valid1_d;
            data_q   <= data_d;
            disp_q   <= disp_d;
            valid2_q <= valid2_d;
        end
    end

    assign po_data      = data_q;
    assign po_valid     = valid2_q;
    assign po_disparity = disp_q;

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Directed-vector bench for tmds_encoder_mc with hand-computed expected symbols.
module tb_tmds_encoder_mc;

    logic        pi_clk = 1'b0;
    logic        pi_rst;
    logic        pi_ce;
    logic [2:0]  pi_mode;
    logic [23:0] pi_data;
    logic [5:0]  pi_control;
    logic [11:0] pi_terc4;
    logic [29:0] po_data;
    logic        po_valid;
    logic [14:0] po_disparity;

    int n_checks = 0;
    int n_fail   = 0;

    tmds_encoder_mc #(
        .NUM_CH (3),
        .DISP_W (5)
    ) dut (
        .pi_clk       (pi_clk),
        .pi_rst       (pi_rst),
        .pi_ce        (pi_ce),
        .pi_mode      (pi_mode),
        .pi_data      (pi_data),
        .pi_control   (pi_control),
        .pi_terc4     (pi_terc4),
        .po_data      (po_data),
        .po_valid     (po_valid),
        .po_disparity (po_disparity)
    );

    always #5 pi_clk = ~pi_clk;

    typedef struct {
        logic [2:0]  mode;
        logic [23:0] data;
        logic [5:0]  ctrl;
        logic [11:0] terc4;
        logic [29:0] exp_data;
        logic [14:0] exp_disp;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [29:0] rep3(input logic [9:0] v);
        return {v, v, v};
    endfunction

    function automatic logic [14:0] rep5(input logic [4:0] v);
        return {v, v, v};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pi_clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] m, input logic [23:0] d, input logic [5:0] c,
                         input logic [11:0] t);
        pi_mode    = m;
        pi_data    = d;
        pi_control = c;
        pi_terc4   = t;
    endtask

    logic [9:0] exp_s[6];
    logic [4:0] dsp_s[6];

    initial begin
        tbl[0]  = '{3'd2 - 3'd2, 24'h0, 6'b110100, 12'h0,
                    {10'b1010101011, 10'b0010101011, 10'b1101010100}, 15'd0};
        tbl[1]  = '{3'd1, 24'h0, 6'h0, 12'h0, rep3(10'h100), rep5(5'b11000)};
        tbl[2]  = '{3'd1, 24'h0, 6'h0, 12'h0, rep3(10'h3FF), rep5(5'b00010)};
        tbl[3]  = '{3'd1, 24'h0, 6'h0, 12'h0, rep3(10'h100), rep5(5'b11010)};
        tbl[4]  = '{3'd3, 24'h0, 6'h0, {4'hC, 4'hF, 4'h0},
                    {10'b1010001110, 10'b1011000011, 10'b1010011100}, 15'd0};
        tbl[5]  = '{3'd4, 24'h0, 6'h0, {4'h0, 4'h0, 4'hC},
                    {10'b0100110011, 10'b0100110011, 10'b1010001110}, 15'd0};
        tbl[6]  = '{3'd2, 24'h0, 6'h0, 12'h0,
                    {10'b1011001100, 10'b0100110011, 10'b1011001100}, 15'd0};
        tbl[7]  = '{3'd1, 24'h0, 6'h0, 12'h0, rep3(10'h100), rep5(5'b11000)};
        tbl[8]  = '{3'd0, 24'h0, 6'h0, 12'h0, rep3(10'b1101010100), 15'd0};
        tbl[9]  = '{3'd1, {8'h10, 8'h55, 8'hFF}, 6'h0, 12'h0,
                    {10'h1F0, 10'h133, 10'h200}, {5'd0, 5'd0, 5'b11000}};
        tbl[10] = '{3'd1, {8'h10, 8'h55, 8'hFF}, 6'h0, 12'h0,
                    {10'h1F0, 10'h133, 10'h0FF}, {5'd0, 5'd0, 5'b11110}};
        tbl[11] = '{3'd1, {8'h10, 8'h55, 8'hFF}, 6'h0, 12'h0,
                    {10'h1F0, 10'h133, 10'h0FF}, {5'd0, 5'd0, 5'b00100}};
        tbl[12] = '{3'd5, 24'h0, 6'b101010, 12'h0, rep3(10'b0101010100), 15'd0};

        exp_s = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h3FF};
        dsp_s = '{5'b11000, 5'b00010, 5'b11010, 5'b00100, 5'b11100, 5'b00110};

        // Reset with random inputs and ce asserted
        pi_rst = 1'b1;
        pi_ce  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(3'($urandom), 24'($urandom), 6'($urandom), 12'($urandom));
            tick();
            check($sformatf("rst_data[%0d]", i), 64'(po_data), 64'd0);
            check($sformatf("rst_valid[%0d]", i), 64'(po_valid), 64'd0);
            check($sformatf("rst_disp[%0d]", i), 64'(po_disparity), 64'd0);
        end
        pi_rst = 1'b0;
        drive(3'd0, 24'h0, 6'h0, 12'h0);
        tick();
        check("valid_after_1_ce", 64'(po_valid), 64'd0);
        tick();
        check("valid_after_2_ce", 64'(po_valid), 64'd1);

        // Continuous table stream; output of vector i-1 appears after edge i
        for (int i = 0; i <= 13; i++) begin
            if (i < 13) drive(tbl[i].mode, tbl[i].data, tbl[i].ctrl, tbl[i].terc4);
            else        drive(3'd0, 24'h0, 6'h0, 12'h0);
            tick();
            if (i >= 1) begin
                check($sformatf("vec%0d_data", i - 1), 64'(po_data), 64'(tbl[i-1].exp_data));
                check($sformatf("vec%0d_disp", i - 1), 64'(po_disparity),
                      64'(tbl[i-1].exp_disp));
                check($sformatf("vec%0d_valid", i - 1), 64'(po_valid), 64'd1);
            end
        end

        // Video stream of zeros with a 5-clock stall after the third output edge
        for (int j = 0; j <= 6; j++) begin
            if (j < 6) drive(3'd1, 24'h0, 6'h0, 12'h0);
            else       drive(3'd0, 24'h0, 6'h0, 12'h0);
            tick();
            if (j >= 1) begin
                check($sformatf("stream%0d_data", j - 1), 64'(po_data), 64'(rep3(exp_s[j-1])));
                check($sformatf("stream%0d_disp", j - 1), 64'(po_disparity),
                      64'(rep5(dsp_s[j-1])));
            end
            if (j == 3) begin
                pi_ce = 1'b0;
                drive(3'd2, 24'hFFFFFF, 6'h3F, 12'hFFF);
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check($sformatf("stall%0d_data", s), 64'(po_data), 64'(rep3(exp_s[2])));
                    check($sformatf("stall%0d_disp", s), 64'(po_disparity),
                          64'(rep5(dsp_s[2])));
                    check($sformatf("stall%0d_valid", s), 64'(po_valid), 64'd1);
                end
                pi_ce = 1'b1;
            end
        end

        // Reset while stalled clears everything on that edge
        pi_ce = 1'b0;
        drive(3'd1, 24'hA5A5A5, 6'h15, 12'h5A5);
        pi_rst = 1'b1;
        tick();
        check("stall_rst_data", 64'(po_data), 64'd0);
        check("stall_rst_valid", 64'(po_valid), 64'd0);
        check("stall_rst_disp", 64'(po_disparity), 64'd0);
        pi_rst = 1'b0;
        pi_ce  = 1'b1;
        drive(3'd0, 24'h0, 6'h0, 12'h0);
        tick();
        check("rerelease_valid_1", 64'(po_valid), 64'd0);
        tick();
        check("rerelease_valid_2", 64'(po_valid), 64'd1);
        check("rerelease_data", 64'(po_data), 64'(rep3(10'b1101010100)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
